// File: rtl/rank_pkg.sv
// Shared types and helpers for the rank frame collector.
package rank_pkg;

    localparam int RANK_DATA_W = 8;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } rank_state_e;

    // Upper median position of a frame.
    function automatic int med_idx(input int frame_len);
        return frame_len / 2;
    endfunction

endpackage

// File: rtl/rank_frame_mem.sv
// Frame buffer: one synchronous write port, two asynchronous read ports
// (replay and statistics tap).
module rank_frame_mem
    import rank_pkg::*;
#(
    parameter int DATA_W    = RANK_DATA_W,
    parameter int FRAME_LEN = 16,
    parameter int PTR_W     = $clog2(FRAME_LEN)
) (
    input  logic              aclk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [PTR_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [FRAME_LEN];

    always_ff @(posedge aclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/rank_frame_collect.sv
// Collects one sorted frame from the rank core, publishes min/max/median and
// an order-violation flag, then replays the frame on a valid/ready stream.
module rank_frame_collect
    import rank_pkg::*;
#(
    parameter int DATA_W    = RANK_DATA_W,
    parameter int FRAME_LEN = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              frame_done,
    output logic [DATA_W-1:0] min_out,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] med_out,
    output logic              sort_err
);

    localparam int               PTR_W       = $clog2(FRAME_LEN);
    localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(FRAME_LEN - 1);
    localparam logic [PTR_W-1:0] MED_IDX     = PTR_W'(med_idx(FRAME_LEN));
    localparam bit               MED_IS_LAST = (med_idx(FRAME_LEN) == FRAME_LEN - 1);

    rank_state_e       state, state_nxt;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DATA_W-1:0] prev, first_smp, rd_data, tap_data;
    logic              err_acc;
    logic              accept, fill_last, xfer, drain_last, dec;

    assign s_ready    = (state == FILL);
    assign accept     = s_valid && s_ready;
    assign fill_last  = accept && (wr_ptr == LAST_IDX);
    assign dec        = (wr_ptr != '0) && (s_data < prev);

    assign m_valid    = (state == DRAIN);
    assign m_last     = m_valid && (rd_ptr == LAST_IDX);
    assign m_data     = m_valid ? rd_data : '0;
    assign xfer       = m_valid && m_ready;
    assign drain_last = xfer && m_last;

    rank_frame_mem #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .PTR_W     (PTR_W)
    ) u_mem (
        .aclk    (aclk),
        .we      (accept),
        .waddr   (wr_ptr),
        .wdata   (s_data),
        .raddr_a (rd_ptr),
        .rdata_a (rd_data),
        .raddr_b (MED_IDX),
        .rdata_b (tap_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (fill_last)  state_nxt = DRAIN;
            DRAIN:   if (drain_last) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // The last sample is still in flight to the buffer when statistics load,
    // so it is taken straight from s_data; index 0 is held in first_smp.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            err_acc    <= 1'b0;
            frame_done <= 1'b0;
            sort_err   <= 1'b0;
            min_out    <= '0;
            max_out    <= '0;
            med_out    <= '0;
        end else begin
            frame_done <= fill_last;
            if (accept) begin
                wr_ptr <= fill_last ? '0 : wr_ptr + 1'b1;
                if (dec) begin
                    err_acc <= 1'b1;
                end
            end
            if (fill_last) begin
                min_out  <= first_smp;
                max_out  <= s_data;
                med_out  <= MED_IS_LAST ? s_data : tap_data;
                sort_err <= err_acc || dec;
            end
            if (xfer) begin
                rd_ptr <= drain_last ? '0 : rd_ptr + 1'b1;
            end
            if (drain_last) begin
                err_acc <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (accept) begin
            prev <= s_data;
            if (wr_ptr == '0) begin
                first_smp <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_rank_frame_collect.sv
// Bench for rank_frame_collect: a 16-sample and a 5-sample instance driven
// side by side and compared every cycle against a frame-level model.
module tb_rank_frame_collect;

    localparam int FLA = 16;
    localparam int FLB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic       sv  [2];
    logic [7:0] sd  [2];
    logic       sr  [2];
    logic       mv  [2];
    logic [7:0] md  [2];
    logic       ml  [2];
    logic       mr  [2];
    logic       fd  [2];
    logic [7:0] mn  [2];
    logic [7:0] mx  [2];
    logic [7:0] me  [2];
    logic       se  [2];

    rank_frame_collect #(.DATA_W(8), .FRAME_LEN(FLA)) dut_a (
        .aclk(clk), .areset(rst[0]), .s_valid(sv[0]), .s_data(sd[0]), .s_ready(sr[0]),
        .m_valid(mv[0]), .m_data(md[0]), .m_last(ml[0]), .m_ready(mr[0]),
        .frame_done(fd[0]), .min_out(mn[0]), .max_out(mx[0]), .med_out(me[0]),
        .sort_err(se[0])
    );

    rank_frame_collect #(.DATA_W(8), .FRAME_LEN(FLB)) dut_b (
        .aclk(clk), .areset(rst[1]), .s_valid(sv[1]), .s_data(sd[1]), .s_ready(sr[1]),
        .m_valid(mv[1]), .m_data(md[1]), .m_last(ml[1]), .m_ready(mr[1]),
        .frame_done(fd[1]), .min_out(mn[1]), .max_out(mx[1]), .med_out(me[1]),
        .sort_err(se[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int k, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s[dut%0d]: got 0x%0h, expected 0x%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic int fl_of(input int k);
        return (k == 0) ? FLA : FLB;
    endfunction

    // Frame-level model: a collect list and a replay list per instance.
    logic [7:0] col [2][16];
    logic [7:0] rep [2][16];
    int         col_n   [2] = '{0, 0};
    int         rep_n   [2] = '{0, 0};
    int         rep_h   [2] = '{0, 0};
    logic [7:0] e_min   [2] = '{0, 0};
    logic [7:0] e_max   [2] = '{0, 0};
    logic [7:0] e_med   [2] = '{0, 0};
    bit         e_done  [2] = '{0, 0};
    bit         e_err   [2] = '{0, 0};
    bit         started [2] = '{0, 0};
    int         done_cnt[2] = '{0, 0};
    int         xfer_cnt[2] = '{0, 0};
    int         last_cnt[2] = '{0, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                col_n[k] = 0; rep_n[k] = 0; rep_h[k] = 0;
                e_min[k] = 0; e_max[k] = 0; e_med[k] = 0;
                e_done[k] = 0; e_err[k] = 0; started[k] = 1;
            end else if (started[k]) begin
                e_done[k] = 0;
                if (rep_n[k] == 0) begin
                    if (sv[k]) begin
                        col[k][col_n[k]] = sd[k];
                        col_n[k]++;
                        if (col_n[k] == fl_of(k)) begin
                            e_done[k] = 1;
                            e_min[k] = col[k][0];
                            e_max[k] = col[k][fl_of(k)-1];
                            e_med[k] = col[k][fl_of(k)/2];
                            e_err[k] = 0;
                            for (int i = 0; i < fl_of(k); i++) begin
                                rep[k][i] = col[k][i];
                                if (i > 0 && col[k][i] < col[k][i-1]) e_err[k] = 1;
                            end
                            rep_n[k] = fl_of(k);
                            rep_h[k] = 0;
                            col_n[k] = 0;
                        end
                    end
                end else if (mr[k]) begin
                    rep_h[k]++;
                    rep_n[k]--;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (started[k]) begin
                chk("s_ready",    k, sr[k], rep_n[k] == 0);
                chk("m_valid",    k, mv[k], rep_n[k] != 0);
                chk("m_data",     k, md[k], (rep_n[k] != 0) ? rep[k][rep_h[k]] : 8'h00);
                chk("m_last",     k, ml[k], rep_n[k] == 1);
                chk("frame_done", k, fd[k], e_done[k]);
                chk("min_out",    k, mn[k], e_min[k]);
                chk("max_out",    k, mx[k], e_max[k]);
                chk("med_out",    k, me[k], e_med[k]);
                chk("sort_err",   k, se[k], e_err[k]);
                if (fd[k]) done_cnt[k]++;
                if (mv[k] && mr[k]) begin
                    xfer_cnt[k]++;
                    if (ml[k]) last_cnt[k]++;
                end
            end
        end
    end

    // m_ready modes: 0 always ready, 1 repeating 1,0,0,1, 2 random.
    int mode[2] = '{0, 0};
    initial begin
        int c;
        c = 0;
        mr[0] = 1'b1;
        mr[1] = 1'b1;
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                case (mode[k])
                    1:       mr[k] = (c % 4 == 0) || (c % 4 == 3);
                    2:       mr[k] = 1'($urandom_range(1));
                    default: mr[k] = 1'b1;
                endcase
            end
            c++;
        end
    end

    logic [7:0] src [2][16];

    task automatic stream(input int k, input int n, input int gap, input bit hold);
        int  i;
        int  g;
        bit  acc;
        i = 0;
        g = 0;
        @(posedge clk); #1;
        while (i < n && g < 1000) begin
            sv[k] = (gap == 0) || ($urandom_range(99) >= gap);
            sd[k] = sv[k] ? src[k][i] : 8'($urandom);
            @(negedge clk);
            acc = sv[k] && sr[k];
            @(posedge clk); #1;
            if (acc) i++;
            g++;
        end
        sv[k] = hold;
        sd[k] = 8'($urandom);
        if (g >= 1000) chk("stream timeout", k, i, n);
    endtask

    task automatic wait_done(input int k, input int mn_e, input int mx_e, input int me_e, input int se_e);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!fd[k] && g < 200);
        if (!fd[k]) begin
            chk("frame_done timeout", k, 0, 1);
        end else begin
            chk("lit min", k, mn[k], mn_e);
            chk("lit max", k, mx[k], mx_e);
            chk("lit med", k, me[k], me_e);
            if (se_e >= 0) chk("lit sort_err", k, se[k], se_e);
        end
    endtask

    task automatic wait_idle(input int k);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!sr[k] && g < 400);
        if (!sr[k]) chk("drain timeout", k, 0, 1);
    endtask

    task automatic do_reset(input int k, input int cycles);
        @(posedge clk); #1;
        rst[k] = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst[k] = 1'b0;
    endtask

    task automatic seq_a();
        int x0;
        int l0;
        int d0;
        int v;
        do_reset(0, 3);
        @(negedge clk);
        chk("lit reset s_ready", 0, sr[0], 1);
        chk("lit reset m_valid", 0, mv[0], 0);
        chk("lit reset min", 0, mn[0], 0);
        chk("lit reset sort_err", 0, se[0], 0);

        // Ascending frame, s_valid kept high into DRAIN.
        for (int i = 0; i < 16; i++) src[0][i] = 8'(i);
        x0 = xfer_cnt[0]; l0 = last_cnt[0];
        stream(0, 16, 0, 1'b1);
        chk("lit s_ready after frame", 0, sr[0], 0);
        wait_done(0, 8'h00, 8'h0F, 8'h08, 0);
        wait_idle(0);
        sv[0] = 1'b0;
        chk("lit xfers", 0, xfer_cnt[0] - x0, 16);
        chk("lit lasts", 0, last_cnt[0] - l0, 1);

        // Same frame under a stalling consumer.
        mode[0] = 1;
        x0 = xfer_cnt[0];
        stream(0, 16, 0, 1'b0);
        wait_done(0, 8'h00, 8'h0F, 8'h08, 0);
        wait_idle(0);
        chk("lit stalled xfers", 0, xfer_cnt[0] - x0, 16);

        // One decrease at index 2.
        mode[0] = 2;
        src[0][0] = 8'h10; src[0][1] = 8'h20; src[0][2] = 8'h18;
        for (int i = 3; i < 16; i++) src[0][i] = 8'(8'h20 + i * 8);
        stream(0, 16, 0, 1'b0);
        wait_done(0, 8'h10, 8'h98, 8'h60, 1);
        wait_idle(0);

        // Clean frame clears the flag.
        for (int i = 0; i < 16; i++) src[0][i] = 8'(i * 3);
        stream(0, 16, 30, 1'b0);
        wait_done(0, 8'h00, 8'h2D, 8'h18, 0);
        wait_idle(0);

        // All-equal frame.
        for (int i = 0; i < 16; i++) src[0][i] = 8'h55;
        stream(0, 16, 0, 1'b0);
        wait_done(0, 8'h55, 8'h55, 8'h55, 0);
        wait_idle(0);

        // Partial frame discarded by reset, then a fresh sorted random frame.
        for (int i = 0; i < 16; i++) src[0][i] = 8'hF0;
        d0 = done_cnt[0];
        stream(0, 7, 0, 1'b0);
        do_reset(0, 1);
        repeat (3) @(negedge clk);
        chk("lit no partial done", 0, done_cnt[0] - d0, 0);
        v = 0;
        for (int i = 0; i < 16; i++) begin
            v += $urandom_range(15);
            src[0][i] = 8'(v);
        end
        stream(0, 16, 20, 1'b0);
        wait_done(0, src[0][0], src[0][15], src[0][8], 0);
        wait_idle(0);
    endtask

    task automatic seq_b();
        int v;
        do_reset(1, 2);
        mode[1] = 2;
        for (int f = 0; f < 3; f++) begin
            v = 0;
            for (int i = 0; i < FLB; i++) begin
                v += $urandom_range(40);
                src[1][i] = (f == 2) ? 8'($urandom) : 8'(v);
            end
            stream(1, FLB, 40, 1'b0);
            wait_done(1, src[1][0], src[1][4], src[1][2], (f == 2) ? -1 : 0);
            wait_idle(1);
            chk("lit b lasts", 1, last_cnt[1], f + 1);
            chk("lit b xfers", 1, xfer_cnt[1], (f + 1) * FLB);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b0;
            sv[k]  = 1'b0;
            sd[k]  = 8'h00;
        end
        fork
            seq_a();
            seq_b();
        join
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
